// File: rtl/adc_bufr_sync_ctrl.sv
// BUFR divider sync sequencer: clears and enables the per-port BUFRs so that
// the divided clocks start phase-aligned. It then confirms that each divided
// clock is toggling, retries on failure and reports READY/ERROR.
module adc_bufr_sync_ctrl #(
  parameter int unsigned PORTS_ADC     = 8,
  parameter int unsigned CLR_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned WINDOW_CYCLES = 256,
  parameter int unsigned MIN_TOGGLES   = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned MONITOR_CONT  = 1
) (
  input  logic                 CLK_I,
  input  logic                 RSTN_I,
  input  logic                 START_I,
  input  logic [PORTS_ADC-1:0] BUFR_CLK_SYNC_I,
  input  logic [PORTS_ADC-1:0] PORT_MASK_I,
  output logic                 BUFR_CLR_O,
  output logic [PORTS_ADC-1:0] BUFR_CE_O,
  output logic [PORTS_ADC-1:0] ALIVE_O,
  output logic                 READY_O,
  output logic                 ERROR_O,
  output logic [3:0]           RETRY_CNT_O
);

  localparam int unsigned CS_MAX  = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX = (CS_MAX > WINDOW_CYCLES) ? CS_MAX : WINDOW_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned TOG_W   = $clog2(MIN_TOGGLES + 1);

  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [TOG_W-1:0] TOG_SAT     = TOG_W'(MIN_TOGGLES);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_CLR, S_SETTLE, S_ENABLE, S_CHECK, S_LOCKED, S_FAIL
  } state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [PORTS_ADC-1:0]            prev_q, prev_d;
  logic [PORTS_ADC-1:0][TOG_W-1:0] tog_q, tog_d;
  logic                            clr_q, clr_d;
  logic [PORTS_ADC-1:0]            ce_q, ce_d;
  logic [PORTS_ADC-1:0]            alive_q, alive_d;
  logic                            ready_q, ready_d;
  logic                            err_q, err_d;
  logic [3:0]                      retry_q, retry_d;

  logic [PORTS_ADC-1:0][TOG_W-1:0] tog_inc;
  logic [PORTS_ADC-1:0]            alive_now;
  logic                            win_active;
  logic                            win_end;
  logic                            pass;

  // State and registered outputs
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q <= S_CLR;
      cnt_q   <= '0;
      prev_q  <= '0;
      tog_q   <= '0;
      clr_q   <= 1'b1;
      ce_q    <= '0;
      alive_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      tog_q   <= tog_d;
      clr_q   <= clr_d;
      ce_q    <= ce_d;
      alive_q <= alive_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

  // Sequencing, edge counting and window decisions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    prev_d    = prev_q;
    tog_d     = tog_q;
    ce_d      = ce_q;
    alive_d   = alive_q;
    retry_d   = retry_q;
    tog_inc   = tog_q;
    alive_now = '0;

    win_active = (state_q == S_CHECK) || ((state_q == S_LOCKED) && (MONITOR_CONT != 0));
    win_end    = win_active && (cnt_q == WIN_LAST);

    // Saturating per-port edge count including this cycle's sample
    for (int unsigned i = 0; i < PORTS_ADC; i++) begin
      if ((prev_q[i] != BUFR_CLK_SYNC_I[i]) && (tog_q[i] != TOG_SAT)) begin
        tog_inc[i] = tog_q[i] + TOG_W'(1);
      end
      alive_now[i] = (tog_inc[i] == TOG_SAT);
    end
    pass = &(alive_now | ~PORT_MASK_I);

    // The first sample of a window only reloads prev and never counts as an edge
    if (win_active) begin
      prev_d = BUFR_CLK_SYNC_I;
      tog_d  = (cnt_q == '0) ? '0 : tog_inc;
    end

    case (state_q)
      S_CLR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_ENABLE;
          cnt_d   = '0;
        end
      end
      S_ENABLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end
      end
      S_CHECK: begin
        if (win_end) begin
          cnt_d   = '0;
          alive_d = alive_now;
          if (pass) begin
            state_d = S_LOCKED;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = S_CLR;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_LOCKED: begin
        if (MONITOR_CONT == 0) begin
          cnt_d = cnt_q;
        end else if (win_end) begin
          cnt_d   = '0;
          alive_d = alive_now;
          if (!pass) begin
            retry_d = '0;
            state_d = S_CLR;
          end
        end
      end
      S_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_CLR;
        cnt_d   = '0;
      end
    endcase

    // A restart request overrides everything, including a same-cycle decision
    if (START_I) begin
      state_d = S_CLR;
      cnt_d   = '0;
      retry_d = '0;
      alive_d = alive_q;
    end

    // Outputs follow the next state so they line up with it
    clr_d   = (state_d == S_CLR);
    err_d   = (state_d == S_FAIL);
    ready_d = (state_d == S_LOCKED) && (state_q == S_LOCKED);
    if ((state_d == S_CLR) || (state_d == S_FAIL)) begin
      ce_d = '0;
    end else if ((state_d == S_ENABLE) && (state_q != S_ENABLE)) begin
      ce_d = PORT_MASK_I;
    end
  end

  assign BUFR_CLR_O  = clr_q;
  assign BUFR_CE_O   = ce_q;
  assign ALIVE_O     = alive_q;
  assign READY_O     = ready_q;
  assign ERROR_O     = err_q;
  assign RETRY_CNT_O = retry_q;

endmodule

// File: tb/tb_adc_bufr_sync_ctrl.sv
// Directed bench for adc_bufr_sync_ctrl: default instance plus a small
// instance (MIN_TOGGLES=8) for the toggle-count boundary.
module tb_adc_bufr_sync_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default-parameter instance
  logic       rstn = 1'b0, start = 1'b0;
  logic [7:0] bclk = '0, mask = 8'hFF, tog_en = 8'hFF;
  logic       clr, ready, err;
  logic [7:0] ce, alive;
  logic [3:0] retry;
  logic       phase = 1'b0;

  adc_bufr_sync_ctrl dut (
    .CLK_I(clk), .RSTN_I(rstn), .START_I(start),
    .BUFR_CLK_SYNC_I(bclk), .PORT_MASK_I(mask),
    .BUFR_CLR_O(clr), .BUFR_CE_O(ce), .ALIVE_O(alive),
    .READY_O(ready), .ERROR_O(err), .RETRY_CNT_O(retry)
  );

  // Small instance for the edge-count boundary
  logic       rstn2 = 1'b0, start2 = 1'b0;
  logic [7:0] bclk2 = '0, mask2 = 8'h01;
  logic       clr2, ready2, err2;
  logic [7:0] ce2, alive2;
  logic [3:0] retry2;

  adc_bufr_sync_ctrl #(
    .PORTS_ADC(8), .CLR_CYCLES(4), .SETTLE_CYCLES(2), .WINDOW_CYCLES(64),
    .MIN_TOGGLES(8), .MAX_RETRY(0), .MONITOR_CONT(0)
  ) dut2 (
    .CLK_I(clk), .RSTN_I(rstn2), .START_I(start2),
    .BUFR_CLK_SYNC_I(bclk2), .PORT_MASK_I(mask2),
    .BUFR_CLR_O(clr2), .BUFR_CE_O(ce2), .ALIVE_O(alive2),
    .READY_O(ready2), .ERROR_O(err2), .RETRY_CNT_O(retry2)
  );

  // Divided-clock model: enabled ports toggle every 2 cycles, others held low
  always @(negedge clk) begin
    phase = ~phase;
    for (int i = 0; i < 8; i++) begin
      if (!tog_en[i]) bclk[i] = 1'b0;
      else if (phase) bclk[i] = ~bclk[i];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++; if (clr !== 1'b1)   begin errors++; $display("FAIL reset_clr: got %b exp 1", clr); end
    checks++; if (ce !== 8'h00)   begin errors++; $display("FAIL reset_ce: got %h exp 00", ce); end
    checks++; if (alive !== 8'h00) begin errors++; $display("FAIL reset_alive: got %h exp 00", alive); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d exp 0", retry); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_healthy;
    for (int n = 1; n <= 289; n++) begin
      tick();
      if (n == 15) begin checks++; if (clr !== 1'b1) begin errors++; $display("FAIL healthy_clr15: got %b exp 1", clr); end end
      if (n == 16) begin checks++; if (clr !== 1'b0) begin errors++; $display("FAIL healthy_clr16: got %b exp 0", clr); end end
      if (n == 23) begin checks++; if (ce !== 8'h00) begin errors++; $display("FAIL healthy_ce23: got %h exp 00", ce); end end
      if (n == 24) begin checks++; if (ce !== 8'hFF) begin errors++; $display("FAIL healthy_ce24: got %h exp FF", ce); end end
      if (n == 288) begin checks++; if (ready !== 1'b0) begin errors++; $display("FAIL healthy_ready288: got %b exp 0", ready); end end
      if (n == 289) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL healthy_ready289: got %b exp 1", ready); end
        checks++; if (alive !== 8'hFF) begin errors++; $display("FAIL healthy_alive: got %h exp FF", alive); end
        checks++; if (retry !== 4'd0) begin errors++; $display("FAIL healthy_retry: got %0d exp 0", retry); end
      end
    end
  endtask

  // Locked window spans edges 289..544; port 0 stops at 289
  task automatic test_monitor_drop;
    tog_en[0] = 1'b0;
    for (int n = 290; n <= 544; n++) begin
      tick();
      if (n == 543) begin checks++; if (ready !== 1'b1) begin errors++; $display("FAIL drop_ready543: got %b exp 1", ready); end end
      if (n == 544) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL drop_ready: got %b exp 0", ready); end
        checks++; if (clr !== 1'b1)   begin errors++; $display("FAIL drop_clr: got %b exp 1", clr); end
        checks++; if (retry !== 4'd0) begin errors++; $display("FAIL drop_retry: got %0d exp 0", retry); end
        checks++; if (alive !== 8'hFE) begin errors++; $display("FAIL drop_alive: got %h exp FE", alive); end
      end
    end
    tog_en[0] = 1'b1;
  endtask

  // START sampled on window timer 100 (CE edge + 109)
  task automatic test_start_midwindow;
    bit found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (ce === 8'hFF) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_ce_wait: got %h exp FF within 100 cycles", ce); end
    repeat (108) tick();
    pulse_start();
    checks++; if (clr !== 1'b1)    begin errors++; $display("FAIL mid_clr: got %b exp 1", clr); end
    checks++; if (alive !== 8'hFE) begin errors++; $display("FAIL mid_alive_kept: got %h exp FE", alive); end
    for (int n = 1; n <= 289; n++) begin
      tick();
      if (n == 288) begin checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready288: got %b exp 0", ready); end end
      if (n == 289) begin
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL mid_ready289: got %b exp 1", ready); end
        checks++; if (alive !== 8'hFF) begin errors++; $display("FAIL mid_alive: got %h exp FF", alive); end
      end
    end
  endtask

  // Port 3 stuck: four 288-cycle attempts, then S_FAIL
  task automatic test_retry_fail;
    tog_en[3] = 1'b0;
    pulse_start();
    for (int n = 1; n <= 1152; n++) begin
      tick();
      if (n == 288) begin checks++; if (retry !== 4'd1) begin errors++; $display("FAIL retry1: got %0d exp 1", retry); end end
      if (n == 576) begin checks++; if (retry !== 4'd2) begin errors++; $display("FAIL retry2: got %0d exp 2", retry); end end
      if (n == 864) begin checks++; if (retry !== 4'd3) begin errors++; $display("FAIL retry3: got %0d exp 3", retry); end end
      if (n == 1151) begin checks++; if (err !== 1'b0) begin errors++; $display("FAIL retry_err1151: got %b exp 0", err); end end
      if (n == 1152) begin
        checks++; if (err !== 1'b1)    begin errors++; $display("FAIL fail_err: got %b exp 1", err); end
        checks++; if (alive !== 8'hF7) begin errors++; $display("FAIL fail_alive: got %h exp F7", alive); end
        checks++; if (clr !== 1'b0)    begin errors++; $display("FAIL fail_clr: got %b exp 0", clr); end
        checks++; if (ce !== 8'h00)    begin errors++; $display("FAIL fail_ce: got %h exp 00", ce); end
        checks++; if (retry !== 4'd3)  begin errors++; $display("FAIL fail_retry: got %0d exp 3", retry); end
      end
    end
    repeat (20) tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL fail_sticky: got %b exp 1", err); end
  endtask

  task automatic test_start_from_fail;
    tog_en[3] = 1'b1;
    pulse_start();
    checks++; if (clr !== 1'b1)   begin errors++; $display("FAIL restart_clr: got %b exp 1", clr); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL restart_err: got %b exp 0", err); end
    checks++; if (retry !== 4'd0) begin errors++; $display("FAIL restart_retry: got %0d exp 0", retry); end
    for (int n = 1; n <= 289; n++) begin
      tick();
      if (n == 288) begin checks++; if (ready !== 1'b0) begin errors++; $display("FAIL restart_ready288: got %b exp 0", ready); end end
      if (n == 289) begin checks++; if (ready !== 1'b1) begin errors++; $display("FAIL restart_ready289: got %b exp 1", ready); end end
    end
  endtask

  task automatic test_mask_ignore;
    tog_en[3] = 1'b0;
    mask = 8'hF7;
    pulse_start();
    for (int n = 1; n <= 289; n++) begin
      tick();
      if (n == 24) begin checks++; if (ce !== 8'hF7) begin errors++; $display("FAIL mask_ce: got %h exp F7", ce); end end
      if (n == 289) begin
        checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL mask_ready: got %b exp 1", ready); end
        checks++; if (alive !== 8'hF7) begin errors++; $display("FAIL mask_alive: got %h exp F7", alive); end
        checks++; if (retry !== 4'd0)  begin errors++; $display("FAIL mask_retry: got %0d exp 0", retry); end
      end
    end
  endtask

  task automatic test_mask_zero;
    mask = 8'h00;
    pulse_start();
    for (int n = 1; n <= 289; n++) begin
      tick();
      if (n == 24) begin checks++; if (ce !== 8'h00) begin errors++; $display("FAIL zero_ce: got %h exp 00", ce); end end
      if (n == 289) begin checks++; if (ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b exp 1", ready); end end
    end
    tog_en[3] = 1'b1;
    mask = 8'hFF;
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    checks++; if (clr !== 1'b1)    begin errors++; $display("FAIL async_clr: got %b exp 1", clr); end
    checks++; if (ready !== 1'b0)  begin errors++; $display("FAIL async_ready: got %b exp 0", ready); end
    checks++; if (alive !== 8'h00) begin errors++; $display("FAIL async_alive: got %h exp 00", alive); end
    checks++; if (ce !== 8'h00)    begin errors++; $display("FAIL async_ce: got %h exp 00", ce); end
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n == 16) begin checks++; if (clr !== 1'b0) begin errors++; $display("FAIL async_restart_clr: got %b exp 0", clr); end end
      if (n == 24) begin checks++; if (ce !== 8'hFF) begin errors++; $display("FAIL async_restart_ce: got %h exp FF", ce); end end
    end
  endtask

  // Drive exactly nedges edges on port 0 of the small instance inside its window
  task automatic burst2(input int nedges);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (ce2 === 8'h01) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL min_ce_wait: got %h exp 01 within 40 cycles", ce2); end
    repeat (10) tick();
    for (int k = 0; k < nedges; k++) begin
      bclk2[0] = ~bclk2[0];
      tick();
    end
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (ready2 === 1'b1 || err2 === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL min_decision_wait: ready %b err %b, exp one set within 100 cycles", ready2, err2); end
  endtask

  task automatic test_min_toggles;
    @(negedge clk);
    rstn2 = 1'b1;
    burst2(7);
    checks++; if (err2 !== 1'b1)    begin errors++; $display("FAIL min7_err: got %b exp 1", err2); end
    checks++; if (ready2 !== 1'b0)  begin errors++; $display("FAIL min7_ready: got %b exp 0", ready2); end
    checks++; if (alive2 !== 8'h00) begin errors++; $display("FAIL min7_alive: got %h exp 00", alive2); end
    bclk2 = '0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL min_restart_err: got %b exp 0", err2); end
    burst2(8);
    checks++; if (ready2 !== 1'b1)  begin errors++; $display("FAIL min8_ready: got %b exp 1", ready2); end
    checks++; if (err2 !== 1'b0)    begin errors++; $display("FAIL min8_err: got %b exp 0", err2); end
    checks++; if (alive2 !== 8'h01) begin errors++; $display("FAIL min8_alive: got %h exp 01", alive2); end
  endtask

  initial begin
    test_reset();
    test_healthy();
    test_monitor_drop();
    test_start_midwindow();
    test_retry_fail();
    test_start_from_fail();
    test_mask_ignore();
    test_mask_zero();
    test_min_toggles();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
